// File: rtl/fir_regs_pkg.sv
// Shared constants for the FIR control register block: register offsets,
// CTRL/STATUS bit positions, FSM encodings and a byte-strobe merge helper.
package fir_regs_pkg;

  localparam int FIR_ADDR_BITS = 8;
  localparam int FIR_COEF_NUM  = 25;
  localparam int FIR_COEF_BITS = 16;
  localparam int FIR_DIM_BITS  = 11;

  // Byte offsets of the register map.
  localparam int REG_CTRL   = 'h00;
  localparam int REG_STATUS = 'h04;
  localparam int REG_WIDTH  = 'h08;
  localparam int REG_HEIGHT = 'h0C;
  localparam int REG_SCALE  = 'h10;
  localparam int REG_COMMIT = 'h14;
  localparam int COEF_BASE  = 'h20;

  // CTRL bits.
  localparam int CTRL_START    = 0;
  localparam int CTRL_ENABLE   = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_SOFT_RST = 3;

  // STATUS bits.
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_COEF_PEND = 2;
  localparam int STAT_START_ERR = 3;

  // Control FSM encodings; BUSY is simply "state == ST_RUN".
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Merge the low two bytes of a write into a 16-bit register image.
  function automatic logic [15:0] merge16(input logic [15:0] old_val,
                                          input logic [15:0] new_val,
                                          input logic [1:0]  strb);
    merge16 = {strb[1] ? new_val[15:8] : old_val[15:8],
               strb[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage

// File: rtl/fir_ctrl_regs_if.sv
// Strobe-style register bus between the AXI4-Lite slave (master side)
// and the FIR control register block (slave side).
interface fir_ctrl_regs_if #(
  parameter int ADDR_BITS = 8
);
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 wr_en;
  logic [31:0]          wr_data;
  logic [3:0]           wr_strb;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_en;
  logic [31:0]          rd_data;

  modport master (output wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
                  input  rd_data);
  modport slave  (input  wr_addr, wr_en, wr_data, wr_strb, rd_addr, rd_en,
                  output rd_data);
endinterface

// File: rtl/fir_ctrl_regs.sv
// Register file and frame sequencer for the 2D FIR filter. Holds image
// geometry, output scale and a double-buffered 5x5 kernel; software writes
// the shadow bank and a commit copies it to the active bank while idle.
module fir_ctrl_regs
  import fir_regs_pkg::*;
#(
  parameter int ADDR_BITS = FIR_ADDR_BITS,
  parameter int COEF_NUM  = FIR_COEF_NUM,
  parameter int COEF_BITS = FIR_COEF_BITS,
  parameter int DIM_BITS  = FIR_DIM_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  fir_ctrl_regs_if.slave                reg_bus,
  input  logic                          i_frame_done,
  output logic                          o_frame_start,
  output logic                          o_filt_en,
  output logic [DIM_BITS-1:0]           o_img_width,
  output logic [DIM_BITS-1:0]           o_img_height,
  output logic [4:0]                    o_scale_sh,
  output logic [COEF_NUM*COEF_BITS-1:0] o_coef_flat,
  output logic                          o_irq
);

  localparam int WB = ADDR_BITS - 2;  // word-address width
  localparam logic [WB-1:0] W_CTRL     = WB'(REG_CTRL >> 2);
  localparam logic [WB-1:0] W_STATUS   = WB'(REG_STATUS >> 2);
  localparam logic [WB-1:0] W_WIDTH    = WB'(REG_WIDTH >> 2);
  localparam logic [WB-1:0] W_HEIGHT   = WB'(REG_HEIGHT >> 2);
  localparam logic [WB-1:0] W_SCALE    = WB'(REG_SCALE >> 2);
  localparam logic [WB-1:0] W_COMMIT   = WB'(REG_COMMIT >> 2);
  localparam logic [WB-1:0] W_COEF0    = WB'(COEF_BASE >> 2);
  localparam logic [WB-1:0] W_COEF_END = WB'((COEF_BASE >> 2) + COEF_NUM);

  logic [0:0]          r_state;
  logic                r_enable, r_irq_en, r_done, r_start_err, r_coef_pend;
  logic                r_launch, r_frame_start, r_irq;
  logic [DIM_BITS-1:0] r_width, r_height, r_img_width, r_img_height;
  logic [4:0]          r_scale, r_scale_sh;

  logic [COEF_NUM-1:0][COEF_BITS-1:0] w_shadow, w_active;

  // ---- write decode --------------------------------------------------------
  logic [WB-1:0] w_wr_word, w_wr_idx, w_rd_word, w_rd_idx;
  logic          w_wr_b0, w_ctrl_wr, w_status_wr, w_coef_wr;
  logic          w_start, w_soft_rst, w_done_clr, w_err_clr, w_commit_wr;
  logic          w_start_ok, w_commit_apply;
  logic [15:0]   w_width_m, w_height_m;

  assign w_wr_word   = reg_bus.wr_addr[ADDR_BITS-1:2];
  assign w_wr_idx    = w_wr_word - W_COEF0;
  assign w_wr_b0     = reg_bus.wr_en & reg_bus.wr_strb[0];
  assign w_ctrl_wr   = w_wr_b0 & (w_wr_word == W_CTRL);
  assign w_status_wr = w_wr_b0 & (w_wr_word == W_STATUS);
  assign w_coef_wr   = reg_bus.wr_en & (w_wr_word >= W_COEF0) & (w_wr_word < W_COEF_END);
  // A write carrying both START and SOFT_RST is treated as a soft reset only.
  assign w_soft_rst  = w_ctrl_wr & reg_bus.wr_data[CTRL_SOFT_RST];
  assign w_start     = w_ctrl_wr & reg_bus.wr_data[CTRL_START] & ~reg_bus.wr_data[CTRL_SOFT_RST];
  assign w_done_clr  = w_status_wr & reg_bus.wr_data[STAT_DONE];
  assign w_err_clr   = w_status_wr & reg_bus.wr_data[STAT_START_ERR];
  assign w_commit_wr = w_wr_b0 & (w_wr_word == W_COMMIT) & reg_bus.wr_data[0];
  assign w_start_ok  = (r_width != '0) & (r_height != '0) & r_enable;
  assign w_commit_apply = r_coef_pend & (r_state == ST_IDLE) & ~w_soft_rst;

  assign w_width_m  = merge16(16'(r_width),  reg_bus.wr_data[15:0], reg_bus.wr_strb[1:0]);
  assign w_height_m = merge16(16'(r_height), reg_bus.wr_data[15:0], reg_bus.wr_strb[1:0]);

  // ---- control FSM next-state ---------------------------------------------
  logic [0:0] w_state_nxt;
  logic       w_accept, w_done_set, w_err_set;

  // Decide the FSM transition and which sticky status bits get set this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_start_ok) begin
            w_state_nxt = ST_RUN;
            w_accept    = 1'b1;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_frame_done) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end
        if (w_start) w_err_set = 1'b1;
      end
    endcase
  end

  // FSM state, sticky status (set beats W1C) and the delayed start pulse.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignment so every flop sees pre-edge values.
    if (rst) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_start_err   <= 1'b0;
      r_coef_pend   <= 1'b0;
      r_launch      <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_soft_rst) begin
      r_state       <= ST_IDLE;
      r_done        <= 1'b0;
      r_start_err   <= 1'b0;
      r_coef_pend   <= 1'b0;
      r_launch      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_done        <= w_done_set | (r_done & ~w_done_clr);
      r_start_err   <= w_err_set | (r_start_err & ~w_err_clr);
      r_coef_pend   <= w_commit_wr | (r_coef_pend & ~w_commit_apply);
      r_launch      <= w_accept;
      r_frame_start <= r_launch;
    end
  end

  // Software-visible configuration registers with per-byte write enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
      r_width  <= '0;
      r_height <= '0;
      r_scale  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_enable <= reg_bus.wr_data[CTRL_ENABLE];
        r_irq_en <= reg_bus.wr_data[CTRL_IRQ_EN];
      end
      if (reg_bus.wr_en && w_wr_word == W_WIDTH)  r_width  <= w_width_m[DIM_BITS-1:0];
      if (reg_bus.wr_en && w_wr_word == W_HEIGHT) r_height <= w_height_m[DIM_BITS-1:0];
      if (w_wr_b0 && w_wr_word == W_SCALE)        r_scale  <= reg_bus.wr_data[4:0];
    end
  end

  // Freeze geometry and scale for the datapath when a frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_img_width  <= '0;
      r_img_height <= '0;
      r_scale_sh   <= '0;
    end else if (w_accept) begin
      r_img_width  <= r_width;
      r_img_height <= r_height;
      r_scale_sh   <= r_scale;
    end
  end

  // Interrupt is a registered view of DONE gated by IRQ_EN.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= r_done & r_irq_en;
  end

  // ---- coefficient banks ---------------------------------------------------
  for (genvar i = 0; i < COEF_NUM; i++) begin : g_tap
    localparam logic [COEF_BITS-1:0] IDENT = COEF_BITS'(i == COEF_NUM / 2);
    logic [COEF_BITS-1:0] r_shadow, r_active;
    logic [15:0]          w_coef_m;

    assign w_coef_m = merge16(16'(r_shadow), reg_bus.wr_data[15:0], reg_bus.wr_strb[1:0]);

    // Shadow tap written by software; active tap loaded from shadow on commit.
    always_ff @(posedge clk) begin
      // NOTE: the taps are flops, not RAM, so reset can load the identity kernel.
      if (rst) begin
        r_shadow <= IDENT;
        r_active <= IDENT;
      end else begin
        if (w_coef_wr && w_wr_idx == WB'(i)) r_shadow <= w_coef_m[COEF_BITS-1:0];
        if (w_commit_apply)                  r_active <= r_shadow;
      end
    end

    assign w_shadow[i] = r_shadow;
    assign w_active[i] = r_active;
  end

  // ---- read mux ------------------------------------------------------------
  logic [COEF_BITS-1:0] w_rd_coef;

  assign w_rd_word = reg_bus.rd_addr[ADDR_BITS-1:2];
  assign w_rd_idx  = w_rd_word - W_COEF0;

  // Combinational register readback; reads have no side effects.
  always_comb begin
    reg_bus.rd_data = '0;
    w_rd_coef       = '0;
    for (int i = 0; i < COEF_NUM; i++) begin
      if (w_rd_idx == WB'(i)) w_rd_coef = w_shadow[i];
    end
    case (w_rd_word)
      W_CTRL: begin
        reg_bus.rd_data[CTRL_ENABLE] = r_enable;
        reg_bus.rd_data[CTRL_IRQ_EN] = r_irq_en;
      end
      W_STATUS: begin
        reg_bus.rd_data[STAT_BUSY]      = (r_state == ST_RUN);
        reg_bus.rd_data[STAT_DONE]      = r_done;
        reg_bus.rd_data[STAT_COEF_PEND] = r_coef_pend;
        reg_bus.rd_data[STAT_START_ERR] = r_start_err;
      end
      W_WIDTH:  reg_bus.rd_data = 32'(r_width);
      W_HEIGHT: reg_bus.rd_data = 32'(r_height);
      W_SCALE:  reg_bus.rd_data = 32'(r_scale);
      default: begin
        if (w_rd_word >= W_COEF0 && w_rd_word < W_COEF_END)
          reg_bus.rd_data = {{(32 - COEF_BITS){w_rd_coef[COEF_BITS-1]}}, w_rd_coef};
      end
    endcase
  end

  // rd_en is reserved and the byte-lane bits below are intentionally unused.
  logic w_unused;
  assign w_unused = ^{reg_bus.rd_en, reg_bus.wr_data[31:16], reg_bus.wr_strb[3:2],
                      reg_bus.wr_addr[1:0], reg_bus.rd_addr[1:0],
                      w_width_m[15:DIM_BITS], w_height_m[15:DIM_BITS]};

  assign o_frame_start = r_frame_start;
  assign o_filt_en     = r_enable;
  assign o_img_width   = r_img_width;
  assign o_img_height  = r_img_height;
  assign o_scale_sh    = r_scale_sh;
  assign o_coef_flat   = w_active;
  assign o_irq         = r_irq;

endmodule
